clut_cache_filler: RTL
======================

Name: clut_cache_filler

Overview:
- Fill controller for the GPU CLUT cache: the writer side of the cache's 8x32-bit block-fill port.
- On a palette request from the texture pipeline it checks tag and block-valid state, then issues 8-word burst reads to the VRAM arbiter.
- Each returned word is pushed into the cache as {blockIndex, idxInBlk, colors}.
- Tracks per-block validity so repeated requests for the same CLUT cost no memory traffic.

Parameters:
- ADDR_W, 18, VRAM word-address width (512 rows x 512 words).
- NUM_BLOCKS, 16, cache blocks of 16 colours each (256 colours total).
- BLOCK_WORDS, 8, 32-bit words per block (2 colours per word).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_loadReq  in  1  palette request pulse; accepted only when o_busy=0.
- i_clutX  in  6  CLUT X position in 16-halfword units.
- i_clutY  in  9  CLUT Y row.
- i_is8bpp  in  1  1: 256-colour palette (16 blocks); 0: 16-colour palette (block 0 only).
- i_invalidate  in  1  VRAM write overlapped the cached CLUT; drop all valid bits.
- o_busy  out  1  request accepted and not yet resolved.
- o_ready  out  1  cache holds the complete palette for the last accepted request.
- o_memReq  out  1  burst read request; held until acknowledged.
- o_memAddr  out  ADDR_W  word address of the burst start.
- i_memAck  in  1  arbiter accepted the burst.
- i_memDataValid  in  1  one data beat on i_memData.
- i_memData  in  32  data beat: two 15-bit-plus-mask colours.
- o_write  out  1  cache write strobe.
- o_writeBlockIndex  out  4  cache block being filled.
- o_writeIdxInBlk  out  3  word index within the block.
- o_Colors  out  32  word to write.

Behaviour:
- Reset: asynchronous, active-high. All outputs are 0; state=IDLE; valid[15:0]=0; tagValid=0.
  - Reset asserted mid-burst abandons the burst. Remaining arbiter beats are the arbiter's concern, since it is reset from the same i_rst.
- States: IDLE, CHECK, REQ, DATA, DONE.
- IDLE:
  - i_loadReq=1 registers X/Y/is8bpp, sets o_busy=1, clears o_ready, and moves to CHECK.
  - If the tag {X,Y} differs from the stored tag, or tagValid=0: valid is cleared, the new tag is stored, tagValid=1.
- CHECK:
  - Required set is {0} for 4bpp and {0..15} for 8bpp.
  - Selects the lowest required block with valid=0.
  - If none is missing: go to DONE.
  - Otherwise: go to REQ with curBlk = that block.
- REQ:
  - o_memReq=1.
  - o_memAddr = clutY*512 + ((clutX + curBlk) mod 64)*8, i.e. wrap-around within the row.
  - Stays in REQ until i_memAck=1, then moves to DATA with beat=0.
- DATA:
  - Each i_memDataValid produces, on the next edge, o_write=1, o_writeBlockIndex=curBlk, o_writeIdxInBlk=beat, o_Colors=i_memData. Then beat increments.
  - o_write is a registered one-cycle pulse per beat.
  - After beat 7 is written: valid[curBlk]=1 (unless an invalidate occurred during the burst), then go to CHECK.
- DONE: o_ready=1, o_busy=0, then IDLE. o_ready stays high until the next accepted request or an invalidate.
- i_invalidate:
  - Clears valid[] and o_ready the next edge, in any state.
  - During DATA the burst drains fully (8 writes still issued) but the block is not marked valid. CHECK then refetches.
  - Invalidate in the same cycle as an accepted request: invalidate applies first, so the request misses.
- Latency:
  - Hit: request accepted at edge N; o_ready=1 and o_busy=0 after edge N+2.
  - Miss: o_memReq rises after edge N+2.
  - Last write pulse of the final block is followed by CHECK, then DONE.
- o_memReq never asserts outside REQ. i_memDataValid outside DATA is ignored.

Decomposition:
- Shared package clut_fill_pkg:
  - state enum;
  - constants NUM_BLOCKS=16, BLOCK_WORDS=8, CLUT_ROW_WORDS=512;
  - address-compose function.
- One sub-module, clut_valid_tracker, holding:
  - the tag and tagValid;
  - valid[15:0] with set/clear/invalidate;
  - a priority encoder giving the lowest missing required block plus an allValid flag.

Test Plan:
- 4bpp miss, X=3, Y=480: one burst at addr 480*512+24=245784; 8 writes to block 0, idx 0..7, colours echoed; o_ready after the final CHECK.
- Repeat the same 4bpp request: no o_memReq; o_ready=1 two edges after accept.
- 8bpp, X=60, Y=0, after a 4bpp load of the same tag:
  - 15 bursts for blocks 1..15 only;
  - block 4 address = ((60+4) mod 64)*8 = 0, checking wrap-around;
  - 120 write pulses.
- Tag change from X=3 to X=4 with 4bpp: valid cleared; reload of block 0 from addr 32.
- i_invalidate on beat 3 of a block-0 burst: 8 writes still issued; o_ready stays 0; a second burst for block 0 follows.
- i_rst asserted while in DATA with i_memAck stalled: all outputs 0 immediately; valid=0; the next request misses.

Source files
------------

// File: rtl/clut_fill_pkg.sv
// Shared definitions for the CLUT cache fill controller.
//   fillState_t    : fill FSM states
//   NUM_BLOCKS     : cache blocks per full 256-colour palette
//   BLOCK_WORDS    : 32-bit words per block
//   CLUT_ROW_WORDS : VRAM words per row
//   composeAddr()  : VRAM word address of the first word of a palette block
package clut_fill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        DATA,
        DONE
    } fillState_t;

    localparam int NUM_BLOCKS     = 16;
    localparam int BLOCK_WORDS    = 8;
    localparam int CLUT_ROW_WORDS = 512;

    // Row-major address: clutY selects the 512-word row. The block column
    // wraps inside the row (6-bit add), so a palette starting near the right
    // edge continues at column 0 of the same row.
    function automatic logic [17:0] composeAddr(input logic [8:0] clutY,
                                                input logic [5:0] clutX,
                                                input logic [3:0] blk);
        logic [5:0] col;
        col = clutX + {2'b00, blk};
        return {clutY, col, 3'b000};
    endfunction

endpackage

// File: rtl/clut_valid_tracker.sv
// Tag and per-block validity bookkeeping for the CLUT cache.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   tagLoad      : request accepted this cycle; compare/replace the tag
//   newTag       : {clutY, clutX} of the incoming request
//   invalidate   : drop every valid bit
//   setValid     : mark block setBlk as fully loaded
//   setBlk       : block to mark
//   is8bpp       : required set is all blocks (1) or block 0 only (0)
//   missBlk      : lowest required block that is not valid
//   allValid     : no required block is missing
module clut_valid_tracker (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        tagLoad,
    input  logic [14:0] newTag,
    input  logic        invalidate,
    input  logic        setValid,
    input  logic [3:0]  setBlk,
    input  logic        is8bpp,
    output logic [3:0]  missBlk,
    output logic        allValid
);
    import clut_fill_pkg::*;

    logic [14:0]           tag;
    logic                  tagValid;
    logic [NUM_BLOCKS-1:0] valid;
    logic [NUM_BLOCKS-1:0] required;
    logic [NUM_BLOCKS-1:0] missing;
    logic                  tagMiss;

    assign tagMiss = tagLoad && (!tagValid || (newTag != tag));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag      <= '0;
            tagValid <= 1'b0;
            valid    <= '0;
        end else begin
            if (tagMiss) begin
                tag      <= newTag;
                tagValid <= 1'b1;
            end
            // Clearing wins over a same-cycle set so a block filled while
            // VRAM was being overwritten is never trusted.
            if (invalidate || tagMiss)
                valid <= '0;
            else if (setValid)
                valid[setBlk] <= 1'b1;
        end
    end

    always_comb begin
        required = is8bpp ? '1 : NUM_BLOCKS'(1);
        missing  = required & ~valid;
        missBlk  = '0;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--)
            if (missing[i])
                missBlk = 4'(i);
        allValid = (missing == '0);
    end

endmodule

// File: rtl/clut_cache_filler.sv
// Fill controller for the GPU CLUT cache (writer side of the 8x32 block-fill
// port). Checks tag/validity on a palette request, fetches each missing block
// with an 8-word VRAM burst and streams the beats into the cache.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_loadReq         : palette request pulse (taken only while o_busy=0)
//   i_clutX, i_clutY  : CLUT position (16-halfword units, row)
//   i_is8bpp          : 256-colour (16 blocks) or 16-colour (block 0) palette
//   i_invalidate      : VRAM write hit the cached CLUT; drop validity
//   o_busy, o_ready   : request in progress / palette complete in cache
//   o_memReq/Addr     : burst read request to the VRAM arbiter, held until i_memAck
//   i_memDataValid/i_memData : returned burst beats
//   o_write, o_writeBlockIndex, o_writeIdxInBlk, o_Colors : cache write port
module clut_cache_filler #(
    parameter int ADDR_W      = 18,
    parameter int NUM_BLOCKS  = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_loadReq,
    input  logic [5:0]        i_clutX,
    input  logic [8:0]        i_clutY,
    input  logic              i_is8bpp,
    input  logic              i_invalidate,
    output logic              o_busy,
    output logic              o_ready,
    output logic              o_memReq,
    output logic [ADDR_W-1:0] o_memAddr,
    input  logic              i_memAck,
    input  logic              i_memDataValid,
    input  logic [31:0]       i_memData,
    output logic              o_write,
    output logic [3:0]        o_writeBlockIndex,
    output logic [2:0]        o_writeIdxInBlk,
    output logic [31:0]       o_Colors
);
    import clut_fill_pkg::*;

    localparam int BLK_W  = $clog2(NUM_BLOCKS);
    localparam int BEAT_W = $clog2(BLOCK_WORDS);

    fillState_t        state, nextState;
    logic [5:0]        regX;
    logic [8:0]        regY;
    logic              reg8bpp;
    logic [BLK_W-1:0]  curBlk;
    logic [BEAT_W-1:0] beat;
    logic              invalSeen;
    logic              accept;
    logic              beatIn;
    logic              lastBeat;
    logic              setValid;
    logic [3:0]        missBlk;
    logic              allValid;

    assign accept   = (state == IDLE) && i_loadReq;
    assign beatIn   = (state == DATA) && i_memDataValid;
    assign lastBeat = beatIn && (beat == BEAT_W'(BLOCK_WORDS - 1));
    // A block whose burst overlapped an invalidate is written but not trusted.
    assign setValid = lastBeat && !invalSeen && !i_invalidate;
    assign o_busy   = (state != IDLE);

    clut_valid_tracker u_tracker (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .tagLoad    (accept),
        .newTag     ({i_clutY, i_clutX}),
        .invalidate (i_invalidate),
        .setValid   (setValid),
        .setBlk     (curBlk),
        .is8bpp     (reg8bpp),
        .missBlk    (missBlk),
        .allValid   (allValid)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (i_loadReq) nextState = CHECK;
            CHECK:   nextState = allValid ? DONE : REQ;
            REQ:     if (o_memReq && i_memAck) nextState = DATA;
            DATA:    if (lastBeat) nextState = CHECK;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= IDLE;
            regX              <= '0;
            regY              <= '0;
            reg8bpp           <= 1'b0;
            curBlk            <= '0;
            beat              <= '0;
            invalSeen         <= 1'b0;
            o_ready           <= 1'b0;
            o_memReq          <= 1'b0;
            o_memAddr         <= '0;
            o_write           <= 1'b0;
            o_writeBlockIndex <= '0;
            o_writeIdxInBlk   <= '0;
            o_Colors          <= '0;
        end else begin
            state   <= nextState;
            o_write <= beatIn;

            if (accept) begin
                regX    <= i_clutX;
                regY    <= i_clutY;
                reg8bpp <= i_is8bpp;
            end

            if (state == CHECK)
                curBlk <= missBlk;

            // The request is registered: it rises one cycle after entering
            // REQ and drops on the edge that samples the acknowledge.
            if (state == REQ) begin
                if (o_memReq && i_memAck) begin
                    o_memReq  <= 1'b0;
                    o_memAddr <= '0;
                    beat      <= '0;
                    invalSeen <= 1'b0;
                end else begin
                    o_memReq  <= 1'b1;
                    o_memAddr <= ADDR_W'(composeAddr(regY, regX, curBlk));
                end
            end

            if (beatIn) begin
                o_writeBlockIndex <= curBlk;
                o_writeIdxInBlk   <= beat;
                o_Colors          <= i_memData;
                beat              <= beat + BEAT_W'(1);
            end

            if ((state == DATA) && i_invalidate)
                invalSeen <= 1'b1;

            if (i_invalidate || accept)
                o_ready <= 1'b0;
            else if (state == DONE)
                o_ready <= 1'b1;
        end
    end

endmodule
